mem_ctlr: RTL and testbench



---
 rtl/mem_ctlr.sv | 134 +++++++++++++
 tb/tb_mem_ctlr.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctlr.sv
// mem_ctlr: arbitrates the dcache and icache request ports onto the single
// memory port. It returns the memory's acceptance tag to the granted cache in
// the same cycle. It also tracks which cache owns each outstanding load tag
// and routes returning data back through a one-cycle registered stage.
// Optional feature: define MEM_CTLR_STARVE_GUARD_EN to add an icache
// starvation guard that forces an icache grant after STARVE_LIMIT
// consecutive denials.
module mem_ctlr #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      dcache2ctlr_command,
    input  logic [XLEN-1:0] dcache2ctlr_addr,
    input  logic [63:0]     dcache2ctlr_data,
    output logic [3:0]      Ctlr2proc_response,
    output logic [63:0]     Ctlr2proc_data,
    output logic [3:0]      Ctlr2proc_tag,
    input  logic [1:0]      icache2ctlr_command,
    input  logic [XLEN-1:0] icache2ctlr_addr,
    output logic [3:0]      Ctlr2icache_response,
    output logic [63:0]     Ctlr2icache_data,
    output logic [3:0]      Ctlr2icache_tag,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic            tag_error
);
    // Bus encodings; BUS_STORE is 2'h2 and is simply "not a load" here.
    localparam logic [1:0] BUS_NONE = 2'h0;
    localparam logic [1:0] BUS_LOAD = 2'h1;

    // The starvation counter is 3 bits, so the limit must be reachable by it.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
        $error("mem_ctlr: STARVE_LIMIT must be in 1..7");
    end

    logic        d_req, i_load, grant_d, grant_i, force_i;
    logic        acc_load, ret_hit, ret_miss;
    logic [15:0] tag_valid;   // entry 0 is never set: tag 0 means "none"
    logic [15:0] tag_owner;   // 0 = dcache, 1 = icache

`ifdef MEM_CTLR_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    assign force_i = i_load && (starve_cnt == 3'(STARVE_LIMIT));

    // Count consecutive cycles the icache waits behind the dcache (saturating).
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (grant_i || !i_load)
            starve_cnt <= '0;
        else if (starve_cnt != 3'd7)
            starve_cnt <= starve_cnt + 3'd1;
    end
`else
    assign force_i = 1'b0;
`endif

    // Grant selection, memory-port mux and acceptance routing.
    always_comb begin
        d_req    = (dcache2ctlr_command != BUS_NONE);
        i_load   = (icache2ctlr_command == BUS_LOAD);
        grant_d  = d_req && !force_i;
        grant_i  = i_load && !grant_d;

        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (grant_d) begin
            proc2mem_command = dcache2ctlr_command;
            proc2mem_addr    = dcache2ctlr_addr;
            proc2mem_data    = dcache2ctlr_data;
        end else if (grant_i) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = icache2ctlr_addr;
        end

        Ctlr2proc_response   = grant_d ? mem2proc_response : 4'd0;
        Ctlr2icache_response = grant_i ? mem2proc_response : 4'd0;

        acc_load = (mem2proc_response != 4'd0) &&
                   ((grant_d && dcache2ctlr_command == BUS_LOAD) || grant_i);
        ret_hit  = (mem2proc_tag != 4'd0) &&  tag_valid[mem2proc_tag];
        ret_miss = (mem2proc_tag != 4'd0) && !tag_valid[mem2proc_tag];
    end

    // Owner table: clear on return, then set on accept so a same-tag accept wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            if (ret_hit)
                tag_valid[mem2proc_tag] <= 1'b0;
            if (acc_load) begin
                tag_valid[mem2proc_response] <= 1'b1;
                tag_owner[mem2proc_response] <= grant_i;
            end
        end
    end

    // Return registers reload every cycle; data goes to the owner seen before this cycle's accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Ctlr2proc_tag    <= '0;
            Ctlr2proc_data   <= '0;
            Ctlr2icache_tag  <= '0;
            Ctlr2icache_data <= '0;
            tag_error        <= 1'b0;
        end else begin
            Ctlr2proc_tag    <= '0;
            Ctlr2proc_data   <= '0;
            Ctlr2icache_tag  <= '0;
            Ctlr2icache_data <= '0;
            if (ret_hit) begin
                if (tag_owner[mem2proc_tag]) begin
                    Ctlr2icache_tag  <= mem2proc_tag;
                    Ctlr2icache_data <= mem2proc_data;
                end else begin
                    Ctlr2proc_tag    <= mem2proc_tag;
                    Ctlr2proc_data   <= mem2proc_data;
                end
            end
            if (ret_miss)
                tag_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_ctlr.sv
// tb_mem_ctlr: directed stimulus for mem_ctlr. A behavioural model of the
// tag/ownership rules is compared against the DUT every cycle, and literal
// expectations pin the key scenarios.
module tb_mem_ctlr;
    localparam int XLEN = 32;
    localparam int STARVE_LIMIT = 4;
    localparam logic [1:0] BUS_NONE  = 2'h0;
    localparam logic [1:0] BUS_LOAD  = 2'h1;
    localparam logic [1:0] BUS_STORE = 2'h2;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]      d_cmd, i_cmd;
    logic [XLEN-1:0] d_addr, i_addr;
    logic [63:0]     d_data, m_data;
    logic [3:0]      m_resp, m_tag;
    logic [3:0]      Ctlr2proc_response, Ctlr2proc_tag, Ctlr2icache_response, Ctlr2icache_tag;
    logic [63:0]     Ctlr2proc_data, Ctlr2icache_data, proc2mem_data;
    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic            tag_error;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    mem_ctlr #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock(clk), .reset(rst),
        .dcache2ctlr_command(d_cmd), .dcache2ctlr_addr(d_addr), .dcache2ctlr_data(d_data),
        .Ctlr2proc_response(Ctlr2proc_response), .Ctlr2proc_data(Ctlr2proc_data),
        .Ctlr2proc_tag(Ctlr2proc_tag),
        .icache2ctlr_command(i_cmd), .icache2ctlr_addr(i_addr),
        .Ctlr2icache_response(Ctlr2icache_response), .Ctlr2icache_data(Ctlr2icache_data),
        .Ctlr2icache_tag(Ctlr2icache_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .mem2proc_response(m_resp), .mem2proc_data(m_data), .mem2proc_tag(m_tag),
        .tag_error(tag_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_valid [16];
    bit        m_icown [16];          // 1 = tag belongs to icache
    bit [3:0]  e_dtag, e_itag;
    bit [63:0] e_ddata, e_idata;
    bit        e_err;
    int        m_streak = 0;

    // Who owns the memory port this cycle: 0 nobody, 1 dcache, 2 icache.
    function automatic int winner();
`ifdef MEM_CTLR_STARVE_GUARD_EN
        if (i_cmd == BUS_LOAD && m_streak == STARVE_LIMIT) return 2;
`endif
        if (d_cmd != BUS_NONE) return 1;
        if (i_cmd == BUS_LOAD) return 2;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int w;
        bit is_load;
        if (rst) begin
            for (int t = 0; t < 16; t++) begin m_valid[t] = 0; m_icown[t] = 0; end
            e_dtag = 0; e_itag = 0; e_ddata = 0; e_idata = 0; e_err = 0; m_streak = 0;
        end else begin
            w = winner();
            e_dtag = 0; e_itag = 0; e_ddata = 0; e_idata = 0;
            if (m_tag != 0) begin
                if (m_valid[m_tag]) begin
                    if (m_icown[m_tag]) begin e_itag = m_tag; e_idata = m_data; end
                    else                begin e_dtag = m_tag; e_ddata = m_data; end
                    m_valid[m_tag] = 0;
                end else begin
                    e_err = 1;
                end
            end
            is_load = (w == 2) || (w == 1 && d_cmd == BUS_LOAD);
            if (is_load && m_resp != 0) begin
                m_valid[m_resp] = 1;
                m_icown[m_resp] = (w == 2);
            end
            if (i_cmd == BUS_LOAD && w == 1) m_streak = (m_streak < 7) ? m_streak + 1 : 7;
            else m_streak = 0;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin : compare
        int w;
        if (cmp_en) begin
            w = winner();
            chk("proc2mem_command", proc2mem_command,
                w == 1 ? d_cmd : (w == 2 ? BUS_LOAD : BUS_NONE));
            chk("proc2mem_addr", proc2mem_addr, w == 1 ? d_addr : (w == 2 ? i_addr : 0));
            chk("proc2mem_data", proc2mem_data, w == 1 ? d_data : 0);
            chk("dcache_response", Ctlr2proc_response, w == 1 ? m_resp : 0);
            chk("icache_response", Ctlr2icache_response, w == 2 ? m_resp : 0);
            chk("dcache_ret_tag", Ctlr2proc_tag, e_dtag);
            chk("dcache_ret_data", Ctlr2proc_data, e_ddata);
            chk("icache_ret_tag", Ctlr2icache_tag, e_itag);
            chk("icache_ret_data", Ctlr2icache_data, e_idata);
            chk("tag_error", tag_error, e_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                         input logic [1:0] ic, input logic [31:0] ia,
                         input logic [3:0] rsp, input logic [3:0] mt, input logic [63:0] md);
        d_cmd = dc; d_addr = da; d_data = dd; i_cmd = ic; i_addr = ia;
        m_resp = rsp; m_tag = mt; m_data = md;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        d_cmd = BUS_NONE; d_addr = 0; d_data = 0; i_cmd = BUS_NONE; i_addr = 0;
        m_resp = 0; m_tag = 0; m_data = 0;
        next();
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_dtag", Ctlr2proc_tag, 4'd0);
        chk("reset_itag", Ctlr2icache_tag, 4'd0);
        chk("reset_err", tag_error, 1'b0);
        next();
        rst = 1'b0;

        // Dcache load accepted with tag 3, returned three cycles later.
        drive(BUS_LOAD, 32'h100, 0, BUS_NONE, 0, 4'd3, 0, 0);
        chk("t1_dresp", Ctlr2proc_response, 4'd3);
        chk("t1_addr", proc2mem_addr, 32'h100);
        next(); idle();
        next(); idle();
        next(); drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd3, 64'hDEAD_BEEF);
        next(); idle();
        chk("t1_ret_tag", Ctlr2proc_tag, 4'd3);
        chk("t1_ret_data", Ctlr2proc_data, 64'hDEAD_BEEF);
        chk("t1_itag", Ctlr2icache_tag, 4'd0);

        // Simultaneous requests: dcache wins, icache accepted once dcache idles.
        next(); drive(BUS_LOAD, 32'h300, 0, BUS_LOAD, 32'h400, 4'd5, 0, 0);
        chk("t2_dresp", Ctlr2proc_response, 4'd5);
        chk("t2_iresp", Ctlr2icache_response, 4'd0);
        chk("t2_addr", proc2mem_addr, 32'h300);
        next(); drive(BUS_NONE, 0, 0, BUS_LOAD, 32'h400, 4'd6, 0, 0);
        chk("t2_iresp2", Ctlr2icache_response, 4'd6);
        chk("t2_iaddr", proc2mem_addr, 32'h400);
        next(); drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd6, 64'hCAFE);
        next(); idle();
        chk("t2_itag", Ctlr2icache_tag, 4'd6);
        chk("t2_idata", Ctlr2icache_data, 64'hCAFE);
        chk("t2_dtag", Ctlr2proc_tag, 4'd0);

        // Same-tag collision: icache owns tag 2; return 2 while dcache is accepted as 2.
        next(); drive(BUS_NONE, 0, 0, BUS_LOAD, 32'h500, 4'd2, 0, 0);
        next(); drive(BUS_LOAD, 32'h600, 0, BUS_NONE, 0, 4'd2, 4'd2, 64'hAB);
        next(); idle();
        chk("t4_itag", Ctlr2icache_tag, 4'd2);
        chk("t4_idata", Ctlr2icache_data, 64'hAB);
        chk("t4_dtag", Ctlr2proc_tag, 4'd0);
        next(); drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd2, 64'hCD);
        next(); idle();
        chk("t4_new_owner_tag", Ctlr2proc_tag, 4'd2);
        chk("t4_new_owner_data", Ctlr2proc_data, 64'hCD);

        // Store: data forwarded, tag not recorded, later return flags an error.
        next(); drive(BUS_STORE, 32'h200, 64'h1234, BUS_NONE, 0, 4'd7, 0, 0);
        chk("t3_pdata", proc2mem_data, 64'h1234);
        chk("t3_pcmd", proc2mem_command, BUS_STORE);
        chk("t3_dresp", Ctlr2proc_response, 4'd7);
        next(); drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd7, 64'h77);
        next(); idle();
        chk("t3_err", tag_error, 1'b1);
        chk("t3_dtag", Ctlr2proc_tag, 4'd0);

`ifdef MEM_CTLR_STARVE_GUARD_EN
        // Starvation guard: the 5th contended cycle goes to the icache.
        for (int k = 1; k <= 5; k++) begin
            next(); drive(BUS_LOAD, 32'h700, 0, BUS_LOAD, 32'h800, 4'd9, 0, 0);
            chk("sg_dresp", Ctlr2proc_response, (k == 5) ? 4'd0 : 4'd9);
            chk("sg_iresp", Ctlr2icache_response, (k == 5) ? 4'd9 : 4'd0);
        end
        next(); idle();
`endif

        // Reset mid-flight: tags 1 and 4 outstanding, dcache return register loaded.
        next(); drive(BUS_LOAD, 32'h900, 0, BUS_NONE, 0, 4'd1, 0, 0);
        next(); drive(BUS_NONE, 0, 0, BUS_LOAD, 32'hA00, 4'd4, 0, 0);
        next(); drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd5, 64'h55);
        next();
        rst = 1'b1;
        idle();
        chk("rst_dtag", Ctlr2proc_tag, 4'd0);
        chk("rst_ddata", Ctlr2proc_data, 64'd0);
        chk("rst_err", tag_error, 1'b0);
        next();
        rst = 1'b0;
        drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd4, 64'h44);
        next(); idle();
        chk("rst_late_err", tag_error, 1'b1);
        chk("rst_late_itag", Ctlr2icache_tag, 4'd0);
        chk("rst_late_dtag", Ctlr2proc_tag, 4'd0);
        next(); idle();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
